// File: rtl/parking_memory_if.sv
// Car-record bus between the gate/billing/display logic and parking_memory.
// Carries the slot selector, write strobes and data, and the combinational read-back.
interface parking_memory_if #(
  parameter int unsigned DW = 10
);
  logic [2:0]    car_sel;
  logic          write_entry;
  logic          write_cost;
  logic [DW-1:0] entry_time_in;
  logic [DW-1:0] cost_in;
  logic [DW-1:0] entry_time_out;
  logic [DW-1:0] cost_out;

  modport master (
    output car_sel, write_entry, write_cost, entry_time_in, cost_in,
    input  entry_time_out, cost_out
  );

  modport slave (
    input  car_sel, write_entry, write_cost, entry_time_in, cost_in,
    output entry_time_out, cost_out
  );
endinterface

// File: rtl/parking_memory.sv
// Per-car record store: SLOTS entries of {entry time, cost}, clocked writes, combinational reads.
// Optional macro MEMORY_BYPASS_EN: write-through of the input data onto the read outputs.
module parking_memory #(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned DW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  parking_memory_if.slave   bus
);
  localparam int unsigned SW = 3;

  logic [DW-1:0] entry_q [SLOTS];
  logic [DW-1:0] cost_q  [SLOTS];
  logic [DW-1:0] entry_rd;
  logic [DW-1:0] cost_rd;

  // One register pair per slot; selectors >= SLOTS match no slot, so those writes drop.
  for (genvar i = 0; i < int'(SLOTS); i++) begin : g_slot
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        entry_q[i] <= '0;
      end else if (bus.write_entry && (bus.car_sel == SW'(i))) begin
        entry_q[i] <= bus.entry_time_in;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cost_q[i] <= '0;
      end else if (bus.write_cost && (bus.car_sel == SW'(i))) begin
        cost_q[i] <= bus.cost_in;
      end
    end
  end

  // Read mux; an unmatched selector falls through to zero.
  always_comb begin
    entry_rd = '0;
    cost_rd  = '0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (bus.car_sel == SW'(i)) begin
        entry_rd = entry_q[i];
        cost_rd  = cost_q[i];
      end
    end
  end

`ifdef MEMORY_BYPASS_EN
  assign bus.entry_time_out = bus.write_entry ? bus.entry_time_in : entry_rd;
  assign bus.cost_out       = bus.write_cost  ? bus.cost_in       : cost_rd;
`else
  assign bus.entry_time_out = entry_rd;
  assign bus.cost_out       = cost_rd;
`endif

endmodule

// File: tb/tb_parking_memory.sv
// Directed bench for parking_memory: reset clear, writes, selector read-back, async reset.
module tb_parking_memory;
  localparam int unsigned DW = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  parking_memory_if #(.DW(DW)) bus ();

  parking_memory #(.SLOTS(8), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%03h, expected 0x%03h", tag, obs, exp);
  endtask

  task automatic expect_slot(input string tag, input logic [2:0] sel,
                             input logic [DW-1:0] e, input logic [DW-1:0] c);
    bus.car_sel = sel;
    #1;
    check({tag, "_entry"}, bus.entry_time_out, e);
    check({tag, "_cost"},  bus.cost_out,       c);
  endtask

  // Present strobes/data, take one rising edge, drop strobes just after it.
  task automatic write_cycle(input logic [2:0] sel, input logic we, input logic [DW-1:0] e,
                             input logic wc, input logic [DW-1:0] c);
    bus.car_sel       = sel;
    bus.write_entry   = we;
    bus.write_cost    = wc;
    bus.entry_time_in = e;
    bus.cost_in       = c;
    @(posedge clk);
    #1;
    bus.write_entry = 1'b0;
    bus.write_cost  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus.car_sel       = 3'd3;
    bus.write_entry   = 1'b1;
    bus.write_cost    = 1'b1;
    bus.entry_time_in = 10'h2AA;
    bus.cost_in       = 10'h155;

    // Writes presented while reset is held must be discarded.
    repeat (2) @(posedge clk);
    #1;
    bus.write_entry = 1'b0;
    bus.write_cost  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int s = 0; s < 8; s++) expect_slot($sformatf("rst_s%0d", s), 3'(s), '0, '0);

    // Slot 1 entry time; check pre-edge visibility before committing the write.
    bus.car_sel       = 3'd1;
    bus.entry_time_in = 10'h123;
    bus.write_entry   = 1'b1;
    #1;
`ifdef MEMORY_BYPASS_EN
    check("pre_edge_entry", bus.entry_time_out, 10'h123);
`else
    check("pre_edge_entry", bus.entry_time_out, 10'h000);
`endif
    write_cycle(3'd1, 1'b1, 10'h123, 1'b0, 10'h000);
    expect_slot("s1_entry_wr", 3'd1, 10'h123, 10'h000);

    write_cycle(3'd1, 1'b0, 10'h000, 1'b1, 10'h056);
    expect_slot("s1_cost_wr", 3'd1, 10'h123, 10'h056);

    write_cycle(3'd2, 1'b1, 10'h389, 1'b0, 10'h000);
    write_cycle(3'd2, 1'b0, 10'h000, 1'b1, 10'h2BC);
    // Selector changes between edges read back without any clock.
    @(negedge clk);
    expect_slot("sel1", 3'd1, 10'h123, 10'h056);
    expect_slot("sel2", 3'd2, 10'h389, 10'h2BC);

    write_cycle(3'd5, 1'b1, 10'h3FF, 1'b1, 10'h001);
    expect_slot("s5_both", 3'd5, 10'h3FF, 10'h001);
    expect_slot("s1_keep", 3'd1, 10'h123, 10'h056);
    expect_slot("s2_keep", 3'd2, 10'h389, 10'h2BC);

    // Held strobe rewrites each edge; last value wins, cost untouched.
    bus.car_sel       = 3'd7;
    bus.write_entry   = 1'b1;
    bus.entry_time_in = 10'h011;
    @(posedge clk); #1;
    bus.entry_time_in = 10'h022;
    @(posedge clk); #1;
    bus.entry_time_in = 10'h033;
    @(posedge clk); #1;
    bus.write_entry   = 1'b0;
    expect_slot("s7_hold", 3'd7, 10'h033, 10'h000);

    // Asynchronous reset between edges clears storage immediately.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_s7_entry", bus.entry_time_out, 10'h000);
    expect_slot("async_s5", 3'd5, 10'h000, 10'h000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_slot("post_s1", 3'd1, 10'h000, 10'h000);
    expect_slot("post_s2", 3'd2, 10'h000, 10'h000);

    // Writes work again after release.
    write_cycle(3'd0, 1'b1, 10'h0AB, 1'b1, 10'h0CD);
    expect_slot("post_wr_s0", 3'd0, 10'h0AB, 10'h0CD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish within 20000 time units");
    $fatal(1);
  end
endmodule
